// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in, serial-out transmitter. A word is accepted
// through a valid/ready handshake and shifted out one bit per clock, framed
// by sout_valid and marked on its final bit by sout_last. A new word may be
// accepted while the last bit of the previous one is on the line, so
// continuous loads produce an unbroken serial stream.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_next_shift;
    logic             on_last_bit;
    logic             out_bit;

    // cnt counts bits remaining including the one currently on the line.
    assign on_last_bit = (state == SHIFT) && (cnt == CNT_ONE);
    assign out_bit     = MSB_FIRST ? sr[WIDTH-1] : sr[0];

    // Move the register one place toward whichever end feeds sout.
    always_comb begin
        sr_next_shift = '0;
        if (MSB_FIRST) begin
            sr_next_shift = {sr[WIDTH-2:0], 1'b0};
        end else begin
            sr_next_shift = {1'b0, sr[WIDTH-1:1]};
        end
    end

    // Handshake and framing outputs derive only from registered state.
    assign load_ready = (state == IDLE) || on_last_bit;
    assign sout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign sout_last  = on_last_bit;
    assign sout       = (state == SHIFT) ? out_bit : 1'b0;

    // Control FSM with the shift register and bit counter it owns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state <= SHIFT;
                        sr    <= data_in;
                        cnt   <= CNT_FULL;
                    end
                end
                SHIFT: begin
                    if (cnt > CNT_ONE) begin
                        sr  <= sr_next_shift;
                        cnt <= cnt - CNT_ONE;
                    end else if (load_valid) begin
                        sr  <= data_in;
                        cnt <= CNT_FULL;
                    end else begin
                        state <= IDLE;
                        sr    <= '0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    sr    <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance share the
// same stimulus; every accepted word pushes its expected bit stream into a
// per-instance queue, and each cycle the front of the queue is compared
// against the serial outputs.
module tb_piso_shift_tx;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk;
    logic         rstn;
    logic         load_valid;
    logic [W-1:0] data_in;

    logic m_ready, m_sout, m_valid, m_last, m_busy;
    logic l_ready, l_sout, l_valid, l_last, l_busy;

    exp_t qm[$];
    exp_t ql[$];

    int checks = 0;
    int errors = 0;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rstn       (rstn),
        .load_valid (load_valid),
        .data_in    (data_in),
        .load_ready (m_ready),
        .sout       (m_sout),
        .sout_valid (m_valid),
        .sout_last  (m_last),
        .busy       (m_busy)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rstn       (rstn),
        .load_valid (load_valid),
        .data_in    (data_in),
        .load_ready (l_ready),
        .sout       (l_sout),
        .sout_valid (l_valid),
        .sout_last  (l_last),
        .busy       (l_busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
            $error("[TB] %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compare one instance against the head of its expected-bit queue.
    task automatic check_dut(input string nm, input int qsize, input exp_t front,
                             input logic vo, input logic so, input logic lo,
                             input logic bo, input logic ro);
        logic ev;
        ev = (qsize > 0);
        check_output({nm, ".sout_valid"}, vo, ev);
        check_output({nm, ".busy"}, bo, ev);
        check_output({nm, ".sout"}, so, ev ? front.b : 1'b0);
        check_output({nm, ".sout_last"}, lo, ev ? front.last : 1'b0);
        check_output({nm, ".load_ready"}, ro, (qsize <= 1));
    endtask

    task automatic check_all(input string step);
        exp_t fm;
        exp_t fl;
        fm = (qm.size() > 0) ? qm[0] : exp_t'(2'b00);
        fl = (ql.size() > 0) ? ql[0] : exp_t'(2'b00);
        check_dut({step, ":msb"}, qm.size(), fm, m_valid, m_sout, m_last, m_busy, m_ready);
        check_dut({step, ":lsb"}, ql.size(), fl, l_valid, l_sout, l_last, l_busy, l_ready);
    endtask

    task automatic push_word(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) qm.push_back('{b: d[i], last: (i == 0)});
        for (int i = 0; i < W; i++) ql.push_back('{b: d[i], last: (i == W - 1)});
    endtask

    // One clock with the inputs currently driven, then check the outputs.
    task automatic apply_stimulus(input string step);
        logic acc;
        acc = rstn && load_valid && (qm.size() <= 1);
        @(posedge clk);
        if (rstn) begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
        end
        if (acc) push_word(data_in);
        #1;
        check_all(step);
    endtask

    task automatic check_reset_outputs(input string step);
        qm.delete();
        ql.delete();
        check_all(step);
    endtask

    initial begin
        rstn       = 1'b0;
        load_valid = 1'b0;
        data_in    = '0;
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        rstn = 1'b1;
        apply_stimulus("idle");

        // Asynchronous reset mid-cycle with load_valid high, held across an edge.
        #2;
        load_valid = 1'b1;
        data_in    = 8'h5A;
        rstn       = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        apply_stimulus("rst_held");
        load_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        apply_stimulus("rst_idle");

        // Single word A5.
        load_valid = 1'b1;
        data_in    = 8'hA5;
        apply_stimulus("a5_load");
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) apply_stimulus("a5_shift");

        // Single word 01 (LSB-first instance sends a lone leading 1).
        load_valid = 1'b1;
        data_in    = 8'h01;
        apply_stimulus("01_load");
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) apply_stimulus("01_shift");

        // Back-to-back A5 then 3C with load_valid held high.
        load_valid = 1'b1;
        data_in    = 8'hA5;
        apply_stimulus("b2b_load1");
        data_in = 8'h3C;
        for (int i = 0; i < W; i++) apply_stimulus("b2b_wait");
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) apply_stimulus("b2b_shift");

        // Loads offered mid-word must be ignored.
        load_valid = 1'b1;
        data_in    = 8'h6B;
        apply_stimulus("ign_load");
        load_valid = 1'b0;
        apply_stimulus("ign_c2");
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            data_in    = 8'hFF;
            apply_stimulus("ign_pulse");
        end
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus("ign_tail");

        // Reset in the middle of a word, then a clean word.
        load_valid = 1'b1;
        data_in    = 8'hF0;
        apply_stimulus("mid_load");
        load_valid = 1'b0;
        apply_stimulus("mid_c2");
        apply_stimulus("mid_c3");
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        apply_stimulus("mid_rst_held");
        @(negedge clk);
        rstn = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'h0F;
        apply_stimulus("0f_load");
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) apply_stimulus("0f_shift");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
